if_id_hazard_ctrl: RTL and testbench
====================================

Name: if_id_hazard_ctrl

Overview:
Hazard and sequencing controller for the IF/ID pipeline register and the PC in the 5-stage MIPS pipeline. Each cycle it decides whether the PC advances, whether IF/ID captures, is held or is flushed to a NOP, and whether a bubble is injected into ID/EX. Covers load-use stalls, ID-stage jumps, EX-stage taken branches and instruction-memory wait.

Parameters:
REG_ADDR_W, 5, register-specifier width
FLUSH_CYCLES, 1, cycles IF/ID is flushed per taken branch (1..15); extra cycles cover deeper fetch latency
CNT_W, 16, width of performance counters (optional feature only)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
id_rs  input  REG_ADDR_W  rs of instruction in ID
id_rt  input  REG_ADDR_W  rt of instruction in ID
id_uses_rt  input  1  ID instruction reads rt as a source
id_jump  input  1  ID instruction is j/jal/jr
idex_mem_read  input  1  instruction in EX is a load
idex_rt  input  REG_ADDR_W  destination rt of instruction in EX
ex_branch_taken  input  1  branch in EX resolved taken
imem_ready  input  1  instruction memory has valid data this cycle
pc_write  output  1  PC register load enable
ifid_write  output  1  IF/ID capture enable
ifid_flush  output  1  IF/ID loads NOP (0x00000000); dominates ifid_write
idex_bubble  output  1  ID/EX control fields forced to zero
ctrl_state  output  2  current FSM state (RUN=0, FLUSH=1, IMEM_WAIT=2)

Behaviour:
- Outputs are combinational from the current state and inputs; state and flush counter are registered on posedge clock.
- While reset_n=0: state=RUN, flush counter=0, pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1. Reset asserted mid-stall or mid-flush aborts immediately. First cycle after release is a normal RUN cycle.
- load_use = idex_mem_read && idex_rt!=0 && (idex_rt==id_rs || (id_uses_rt && idex_rt==id_rt)).
- Event priority in every state: ex_branch_taken > load_use > id_jump > !imem_ready.
- ex_branch_taken (any state): pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. If FLUSH_CYCLES>1, next state is FLUSH and the counter is loaded with FLUSH_CYCLES-1; otherwise next state is RUN.
- FLUSH: pc_write=1, ifid_flush=1, idex_bubble=0. Counter decrements each cycle; at 1 the next state is RUN. A new taken branch reloads the counter. Load-use and jump are ignored because ID holds a NOP.
- RUN with load_use: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, for one cycle only; the state stays RUN. A simultaneous id_jump is deferred because ID is held and re-evaluated next cycle.
- RUN with id_jump (no load_use): pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0. This squashes the fall-through fetch.
- RUN with !imem_ready (no higher event): pc_write=0, ifid_write=1, ifid_flush=1, idex_bubble=0. Next state is IMEM_WAIT.
- IMEM_WAIT: same outputs as the line above while imem_ready=0. When imem_ready=1 the cycle behaves as RUN-normal and the next state is RUN.
- RUN normal: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.

Optional Feature:
IF_ID_PERF_CNT_EN: when defined, adds outputs stall_cnt and flush_cnt, each CNT_W bits and cleared by reset. stall_cnt increments in every post-reset cycle with pc_write=0. flush_cnt increments in every post-reset cycle with ifid_flush=1. Both saturate at all-ones and do not wrap. When the macro is undefined, neither the ports nor the counter logic exist.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> pc_write=0, ifid_flush=1, idex_bubble=1, ctrl_state=0; after release with imem_ready=1 and no hazards -> pc_write=1, ifid_write=1, ifid_flush=0.
- Load-use: idex_mem_read=1, idex_rt=8, id_rs=8 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; next cycle idex_mem_read=0 -> normal. Repeat with idex_rt=0 -> no stall. Repeat with id_rt=8, id_uses_rt=0 -> no stall.
- Taken branch, FLUSH_CYCLES=3: pulse ex_branch_taken -> ifid_flush=1 for exactly 3 cycles, idex_bubble=1 only in the first, ctrl_state sequence 0,1,1,0.
- Simultaneous events: ex_branch_taken=1 with load_use=1 and id_jump=1 -> pc_write=1, ifid_flush=1, idex_bubble=1 (branch wins). load_use=1 with id_jump=1 -> stall cycle, then the jump flush on the next cycle.
- Imem wait: imem_ready low for 4 cycles -> pc_write=0, ifid_flush=1 for 4 cycles, ctrl_state=2 for the last 3; a taken branch on wait cycle 2 -> pc_write=1 that cycle.
- With IF_ID_PERF_CNT_EN, CNT_W=4: force 20 stall cycles -> stall_cnt saturates at 15; reset_n low -> both counters read 0.

Source files
------------

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID and PC sequencing controller: load-use stalls, ID jumps, EX taken branches, imem wait.
// Optional performance counters are enabled with the IF_ID_PERF_CNT_EN macro.
module if_id_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FLUSH_CYCLES = 1
`ifdef IF_ID_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W        = 16
`endif
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_jump,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic                  ex_branch_taken,
  input  logic                  imem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
`ifdef IF_ID_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
`endif
  output logic [1:0]            ctrl_state
);

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StFlush    = 2'd1,
    StImemWait = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;

  assign load_use = idex_mem_read && (idex_rt != '0) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = StFlush;
        cnt_d   = 4'(FLUSH_CYCLES - 1);
      end else begin
        state_d = StRun;
        cnt_d   = 4'd0;
      end
    end else begin
      case (state_q)
        StFlush: begin
          // ID holds a NOP here, so load-use and jump are don't-cares
          ifid_flush = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = StRun;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = StRun;
          end else if (id_jump) begin
            ifid_flush = 1'b1;
            state_d    = StRun;
          end else if (!imem_ready) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            state_d    = StImemWait;
          end else begin
            state_d = StRun;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ctrl_state = state_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: hold at all-ones instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed bench for if_id_hazard_ctrl with FLUSH_CYCLES=3; expected vectors are hand-computed.
module tb_if_id_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic       id_uses_rt, id_jump, idex_mem_read, ex_branch_taken, imem_ready;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0] ctrl_state;
`ifdef IF_ID_PERF_CNT_EN
  logic [3:0] stall_cnt, flush_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Vector layout: {pc_write, ifid_write, ifid_flush, idex_bubble, ctrl_state[1:0]}
  localparam logic [5:0] All   = 6'b111111;
  localparam logic [5:0] NoIfw = 6'b101111;

  always #5 clock = ~clock;

  if_id_hazard_ctrl #(
    .REG_ADDR_W  (5),
    .FLUSH_CYCLES(3)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .CNT_W       (4)
`endif
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .id_jump        (id_jump),
    .idex_mem_read  (idex_mem_read),
    .idex_rt        (idex_rt),
    .ex_branch_taken(ex_branch_taken),
    .imem_ready     (imem_ready),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
`ifdef IF_ID_PERF_CNT_EN
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
`endif
    .ctrl_state     (ctrl_state)
  );

  function automatic logic [5:0] v(input logic pc, input logic ifw, input logic fl,
                                   input logic bub, input logic [1:0] st);
    return {pc, ifw, fl, bub, st};
  endfunction

  task automatic chk(input string tag, input logic [5:0] exp, input logic [5:0] care);
    logic [5:0] obs;
    #1;
    obs = {pc_write, ifid_write, ifid_flush, idex_bubble, ctrl_state};
    vectors++;
    assert ((obs & care) === (exp & care))
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (care %b)", tag, obs, exp, care);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; idex_rt = 5'd0;
    id_uses_rt = 1'b0; id_jump = 1'b0; idex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; imem_ready = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    clr();
    // Reset held for three edges
    chk("rst0", v(0, 0, 1, 1, 0), All); cyc();
    chk("rst1", v(0, 0, 1, 1, 0), All); cyc();
    chk("rst2", v(0, 0, 1, 1, 0), All); cyc();
    reset_n = 1'b1;
    chk("run_after_rst", v(1, 1, 0, 0, 0), All); cyc();

    // Load-use via rs
    idex_mem_read = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    chk("lu_rs_stall", v(0, 0, 0, 1, 0), All); cyc();
    idex_mem_read = 1'b0;
    chk("lu_rs_after", v(1, 1, 0, 0, 0), All); cyc();
    // $zero destination never stalls
    idex_mem_read = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
    chk("lu_r0_none", v(1, 1, 0, 0, 0), All); cyc();
    // rt match only counts when rt is a source
    idex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
    chk("lu_rt_unused", v(1, 1, 0, 0, 0), All); cyc();
    id_uses_rt = 1'b1;
    chk("lu_rt_used", v(0, 0, 0, 1, 0), All); cyc();
    clr();

    // Taken branch: three flush cycles, bubble only in the first
    ex_branch_taken = 1'b1;
    chk("br_c0", v(1, 1, 1, 1, 0), All); cyc();
    ex_branch_taken = 1'b0;
    chk("br_c1", v(1, 1, 1, 0, 1), NoIfw); cyc();
    // Load-use during FLUSH is ignored
    idex_mem_read = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    chk("br_c2_lu_ign", v(1, 1, 1, 0, 1), NoIfw); cyc();
    clr();
    chk("br_c3", v(1, 1, 0, 0, 0), All); cyc();

    // Branch beats load-use and jump
    ex_branch_taken = 1'b1; idex_mem_read = 1'b1; idex_rt = 5'd8; id_rs = 5'd8; id_jump = 1'b1;
    chk("br_wins", v(1, 1, 1, 1, 0), All); cyc();
    clr();
    chk("br_wins_f1", v(1, 1, 1, 0, 1), NoIfw); cyc();
    // Branch during FLUSH reloads the counter
    ex_branch_taken = 1'b1;
    chk("br_reload", v(1, 1, 1, 1, 1), All); cyc();
    ex_branch_taken = 1'b0;
    chk("br_reload_f1", v(1, 1, 1, 0, 1), NoIfw); cyc();
    chk("br_reload_f2", v(1, 1, 1, 0, 1), NoIfw); cyc();
    chk("br_reload_end", v(1, 1, 0, 0, 0), All); cyc();

    // Load-use defers a jump by one cycle
    idex_mem_read = 1'b1; idex_rt = 5'd9; id_rs = 5'd9; id_jump = 1'b1;
    chk("lu_jump_stall", v(0, 0, 0, 1, 0), All); cyc();
    idex_mem_read = 1'b0;
    chk("lu_jump_flush", v(1, 1, 1, 0, 0), All); cyc();
    clr();
    chk("lu_jump_after", v(1, 1, 0, 0, 0), All); cyc();

    // Instruction memory wait for four cycles
    imem_ready = 1'b0;
    chk("iw_c1", v(0, 1, 1, 0, 0), All); cyc();
    chk("iw_c2", v(0, 1, 1, 0, 2), All); cyc();
    chk("iw_c3", v(0, 1, 1, 0, 2), All); cyc();
    chk("iw_c4", v(0, 1, 1, 0, 2), All); cyc();
    imem_ready = 1'b1;
    chk("iw_ready", v(1, 1, 0, 0, 2), All); cyc();
    chk("iw_back_run", v(1, 1, 0, 0, 0), All); cyc();

    // Taken branch on wait cycle 2
    imem_ready = 1'b0;
    chk("iwb_c1", v(0, 1, 1, 0, 0), All); cyc();
    ex_branch_taken = 1'b1;
    chk("iwb_c2_br", v(1, 1, 1, 1, 2), All); cyc();
    ex_branch_taken = 1'b0; imem_ready = 1'b1;
    chk("iwb_f1", v(1, 1, 1, 0, 1), NoIfw); cyc();
    chk("iwb_f2", v(1, 1, 1, 0, 1), NoIfw); cyc();
    chk("iwb_end", v(1, 1, 0, 0, 0), All); cyc();

    // Reset mid-flush aborts immediately
    ex_branch_taken = 1'b1; cyc();
    ex_branch_taken = 1'b0;
    chk("mid_flush", v(1, 1, 1, 0, 1), NoIfw);
    reset_n = 1'b0;
    chk("mid_flush_rst", v(0, 0, 1, 1, 0), All); cyc();
    reset_n = 1'b1;
    chk("mid_flush_run", v(1, 1, 0, 0, 0), All); cyc();

`ifdef IF_ID_PERF_CNT_EN
    reset_n = 1'b0; cyc();
    reset_n = 1'b1; imem_ready = 1'b0;
    repeat (20) cyc();
    vectors++;
    assert (stall_cnt === 4'hF)
    else begin
      miscompares++;
      $error("FAIL stall_sat: observed %h expected %h", stall_cnt, 4'hF);
    end
    vectors++;
    assert (flush_cnt === 4'hF)
    else begin
      miscompares++;
      $error("FAIL flush_sat: observed %h expected %h", flush_cnt, 4'hF);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    assert ({stall_cnt, flush_cnt} === 8'h00)
    else begin
      miscompares++;
      $error("FAIL cnt_rst: observed %h expected %h", {stall_cnt, flush_cnt}, 8'h00);
    end
    cyc();
    reset_n = 1'b1; imem_ready = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
